// File: rtl/converter_seq_pkg.sv
// Shared state codes, fault-cause bit positions and a magnitude helper for the converter sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package converter_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_STARTUP = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // Bit positions inside the 2-bit fault code.
  localparam int FC_OVERCURRENT  = 0;
  localparam int FC_OUT_OF_RANGE = 1;

  // |x| widened to 15 bits so that -8192 maps to +8192 instead of wrapping.
  function automatic logic [14:0] abs15(input logic signed [13:0] x);
    logic [14:0] ext;
    ext = {x[13], x};
    return ext[14] ? (~ext + 15'd1) : ext;
  endfunction

endpackage

// File: rtl/converter_sequencer_fault_monitor.sv
// Fault monitor: overcurrent compare on |ic| and consecutive-cycle filter on the ADC out-of-range flags.
// Latency: cause is combinational from the current sample plus the registered run-length count.
// Backpressure: none; evaluates every cycle.
// Ports: clk/rst (sync, active-high), ic (signed tank current), or_a/or_b (ADC flags),
//        cause[1:0] (bit FC_OVERCURRENT, bit FC_OUT_OF_RANGE).
module fault_monitor
  import converter_seq_pkg::*;
#(
  parameter logic [13:0] I_LIMIT = 14'd6000,
  parameter int          OR_FILT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [13:0] ic,
  input  logic               or_a,
  input  logic               or_b,
  output logic [1:0]         cause
);

  localparam int FW = (OR_FILT > 1) ? $clog2(OR_FILT) : 1;
  localparam logic [FW-1:0] OR_LAST = FW'(OR_FILT - 1);

  logic          or_now;
  logic [FW-1:0] or_cnt;   // consecutive out-of-range cycles seen before this one, saturating at OR_LAST
  logic [14:0]   mag;

  assign or_now = or_a | or_b;
  assign mag    = abs15(ic);

  always_ff @(posedge clk) begin
    if (rst) begin
      or_cnt <= '0;
    end else if (!or_now) begin
      or_cnt <= '0;
    end else if (or_cnt != OR_LAST) begin
      or_cnt <= or_cnt + FW'(1);
    end
  end

  always_comb begin
    cause                  = '0;
    cause[FC_OVERCURRENT]  = (mag > {1'b0, I_LIMIT});
    // The current high cycle completes the run when OR_FILT-1 highs preceded it.
    cause[FC_OUT_OF_RANGE] = or_now && (or_cnt == OR_LAST);
  end

endmodule

// File: rtl/converter_sequencer.sv
// Converter start-up sequencer: IDLE -> ARM -> STARTUP (theta ramp) -> RUN, with latched fault handling.
// Latency: all outputs registered; state and outputs change one cycle after the deciding input.
// Backpressure: none; i_enable is a level request, faults override it.
// Ports: i_clock, i_RESET (sync, active-high), i_enable, i_theta_target, i_iC, i_or_A, i_or_B;
//        o_enable (gate), o_theta, o_state, o_fault_code, o_fault_cnt.
module converter_sequencer
  import converter_seq_pkg::*;
#(
  parameter int                 ARM_CYCLES  = 100,
  parameter int                 RAMP_DIV    = 1000,
  parameter logic signed [31:0] THETA_START = 32'sd0,
  parameter logic signed [31:0] THETA_STEP  = 32'sd1000,
  parameter logic [13:0]        I_LIMIT     = 14'd6000,
  parameter int                 OR_FILT     = 4
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic               i_enable,
  input  logic signed [31:0] i_theta_target,
  input  logic signed [13:0] i_iC,
  input  logic               i_or_A,
  input  logic               i_or_B,
  output logic               o_enable,
  output logic signed [31:0] o_theta,
  output logic [2:0]         o_state,
  output logic [1:0]         o_fault_code,
  output logic [7:0]         o_fault_cnt
);

  localparam int CMAX = (ARM_CYCLES > RAMP_DIV) ? ARM_CYCLES : RAMP_DIV;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] ARM_LAST  = CW'(ARM_CYCLES - 1);
  localparam logic [CW-1:0] RAMP_LAST = CW'(RAMP_DIV - 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cyc_cnt, cyc_cnt_nxt;   // shared by ARM dwell and ramp divider
  logic               enable_nxt;
  logic signed [31:0] theta_nxt;
  logic [1:0]         fault_code_nxt;
  logic [7:0]         fault_cnt_nxt;

  logic [1:0]         cause;
  logic               fault;

  logic signed [32:0] ramp_diff;
  logic [32:0]        ramp_mag;
  logic               ramp_tick;
  logic               ramp_done;
  logic signed [31:0] theta_ramped;

  fault_monitor #(
    .I_LIMIT (I_LIMIT),
    .OR_FILT (OR_FILT)
  ) u_fault_monitor (
    .clk   (i_clock),
    .rst   (i_RESET),
    .ic    (i_iC),
    .or_a  (i_or_A),
    .or_b  (i_or_B),
    .cause (cause)
  );

  assign fault = |cause;

  // Difference taken at 33 bits so far-apart signed values cannot wrap.
  assign ramp_diff    = {i_theta_target[31], i_theta_target} - {o_theta[31], o_theta};
  assign ramp_mag     = ramp_diff[32] ? 33'(-ramp_diff) : 33'(ramp_diff);
  assign ramp_tick    = (cyc_cnt == RAMP_LAST);
  assign ramp_done    = (ramp_mag <= {1'b0, THETA_STEP});
  assign theta_ramped = ramp_done     ? i_theta_target :
                        ramp_diff[32] ? (o_theta - THETA_STEP) :
                                        (o_theta + THETA_STEP);

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      state        <= ST_IDLE;
      cyc_cnt      <= '0;
      o_enable     <= 1'b0;
      o_theta      <= THETA_START;
      o_fault_code <= '0;
      o_fault_cnt  <= '0;
    end else begin
      state        <= state_nxt;
      cyc_cnt      <= cyc_cnt_nxt;
      o_enable     <= enable_nxt;
      o_theta      <= theta_nxt;
      o_fault_code <= fault_code_nxt;
      o_fault_cnt  <= fault_cnt_nxt;
    end
  end

  assign o_state = state;

  // Next state and dwell counter. Fault beats a dropped enable.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_enable) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (fault)                      state_nxt = ST_FAULT;
        else if (!i_enable)             state_nxt = ST_IDLE;
        else if (cyc_cnt == ARM_LAST)   state_nxt = ST_STARTUP;
      end
      ST_STARTUP: begin
        if (fault)                      state_nxt = ST_FAULT;
        else if (!i_enable)             state_nxt = ST_IDLE;
        else if (ramp_tick && ramp_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (fault)                      state_nxt = ST_FAULT;
        else if (!i_enable)             state_nxt = ST_IDLE;
      end
      ST_FAULT: begin
        if (!i_enable)                  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (state_nxt != state) begin
      cyc_cnt_nxt = '0;
    end else if (state == ST_ARM) begin
      cyc_cnt_nxt = cyc_cnt + CW'(1);
    end else if (state == ST_STARTUP) begin
      cyc_cnt_nxt = ramp_tick ? '0 : cyc_cnt + CW'(1);
    end else begin
      cyc_cnt_nxt = '0;
    end
  end

  // Next values of the registered outputs, keyed on where the FSM is heading.
  always_comb begin
    enable_nxt     = (state_nxt == ST_STARTUP) || (state_nxt == ST_RUN);
    theta_nxt      = o_theta;
    fault_code_nxt = '0;
    fault_cnt_nxt  = o_fault_cnt;

    case (state_nxt)
      ST_IDLE, ST_ARM: theta_nxt = THETA_START;
      ST_STARTUP:      if (state == ST_STARTUP && ramp_tick) theta_nxt = theta_ramped;
      ST_RUN:          theta_nxt = i_theta_target;
      default:         theta_nxt = o_theta;   // FAULT holds theta
    endcase

    if (state_nxt == ST_FAULT) begin
      if (state != ST_FAULT) begin
        fault_code_nxt = cause;
        fault_cnt_nxt  = (o_fault_cnt == 8'hFF) ? o_fault_cnt : o_fault_cnt + 8'd1;
      end else begin
        fault_code_nxt = o_fault_code;
      end
    end
  end

endmodule

// File: tb/tb_converter_sequencer.sv
// Self-checking bench for converter_sequencer: directed start-up/fault scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the sequencing rules.
// Clock: 10 ns period; inputs driven 1 ns after the rising edge, outputs sampled 1 ns after it.
module tb_converter_sequencer;

  localparam int     ARM_CYCLES = 8;
  localparam int     RAMP_DIV   = 4;
  localparam longint STEP       = 100;
  localparam longint START      = 0;
  localparam int     LIMIT      = 4000;
  localparam int     FILT       = 3;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [31:0] target;
  logic signed [13:0] ic;
  logic               or_a;
  logic               or_b;
  logic               o_enable;
  logic signed [31:0] o_theta;
  logic [2:0]         o_state;
  logic [1:0]         o_fault_code;
  logic [7:0]         o_fault_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  int     m_st;
  bit     m_en;
  longint m_theta;
  bit [1:0] m_code;
  int     m_cnt;
  int     m_time;     // edges already spent in the current state
  int     or_run;     // length of the current run of out-of-range samples

  converter_sequencer #(
    .ARM_CYCLES  (ARM_CYCLES),
    .RAMP_DIV    (RAMP_DIV),
    .THETA_START (32'sd0),
    .THETA_STEP  (32'sd100),
    .I_LIMIT     (14'd4000),
    .OR_FILT     (FILT)
  ) dut (
    .i_clock        (clk),
    .i_RESET        (rst),
    .i_enable       (en),
    .i_theta_target (target),
    .i_iC           (ic),
    .i_or_A         (or_a),
    .i_or_B         (or_b),
    .o_enable       (o_enable),
    .o_theta        (o_theta),
    .o_state        (o_state),
    .o_fault_code   (o_fault_code),
    .o_fault_cnt    (o_fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, computed from the sequencing rules.
  task automatic model_update();
    longint d;
    int     mag;
    bit     oc, orf;
    int     nst;
    if (rst) begin
      m_st = 0; m_en = 0; m_theta = START; m_code = 0; m_cnt = 0; m_time = 0; or_run = 0;
      return;
    end
    mag    = (ic < 0) ? -int'(ic) : int'(ic);
    oc     = (mag > LIMIT);
    or_run = (or_a || or_b) ? or_run + 1 : 0;
    orf    = (or_run >= FILT);
    nst    = m_st;
    case (m_st)
      0: if (en) nst = 1;
      1, 2, 3: begin
        if (oc || orf) begin
          nst    = 4;
          m_code = {orf, oc};
          m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        end else if (!en) begin
          nst = 0;
        end else if (m_st == 1) begin
          if (m_time + 1 == ARM_CYCLES) nst = 2;
        end else if (m_st == 2) begin
          if ((m_time + 1) % RAMP_DIV == 0) begin
            d = longint'(target) - m_theta;
            if (d <= STEP && d >= -STEP) begin
              m_theta = longint'(target);
              nst     = 3;
            end else begin
              m_theta = m_theta + ((d > 0) ? STEP : -STEP);
            end
          end
        end else begin
          m_theta = longint'(target);
        end
      end
      4: if (!en) begin nst = 0; m_code = 0; end
      default: nst = 0;
    endcase
    if (nst == 0) m_theta = START;
    m_en   = (nst == 2) || (nst == 3);
    m_time = (nst == m_st) ? m_time + 1 : 0;
    m_st   = nst;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("state",      64'(o_state),      64'(m_st));
    chk("enable",     64'(o_enable),     64'(m_en));
    chk("theta",      64'(o_theta),      m_theta);
    chk("fault_code", 64'(o_fault_code), 64'(m_code));
    chk("fault_cnt",  64'(o_fault_cnt),  64'(m_cnt));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_state(input int s, input int budget);
    int k;
    k = 0;
    while (o_state != 3'(s) && k < budget) begin
      step();
      k++;
    end
    chk("wait_state", 64'(o_state), 64'(s));
  endtask

  longint up_seq[4]   = '{100, 200, 300, 350};
  longint down_seq[5] = '{100, 0, -100, -200, -250};

  initial begin
    rst = 1'b1; en = 1'b0; target = 32'sd350; ic = '0; or_a = 1'b0; or_b = 1'b0;
    m_st = 0; m_en = 0; m_theta = START; m_code = 0; m_cnt = 0; m_time = 0; or_run = 0;

    // Reset state.
    run(2);
    chk("rst_state", 64'(o_state), 0);
    chk("rst_theta", 64'(o_theta), 0);
    chk("rst_en",    64'(o_enable), 0);
    chk("rst_cnt",   64'(o_fault_cnt), 0);

    // Start-up to 350: 8 ARM cycles then 4-cycle ramp steps.
    rst = 1'b0; en = 1'b1;
    run(1);
    chk("arm_entry", 64'(o_state), 1);
    run(7);
    chk("arm_hold", 64'(o_state), 1);
    chk("arm_gate_off", 64'(o_enable), 0);
    run(1);
    chk("startup_entry", 64'(o_state), 2);
    chk("startup_gate_on", 64'(o_enable), 1);
    for (int k = 0; k < 4; k++) begin
      run(4);
      chk("ramp_up", 64'(o_theta), up_seq[k]);
    end
    chk("ramp_up_run", 64'(o_state), 3);
    target = 32'sd360;
    run(1);
    chk("run_track", 64'(o_theta), 360);

    // Overcurrent pulse in RUN, then release to IDLE.
    ic = -14'sd4001;
    run(1);
    ic = '0;
    chk("oc_state", 64'(o_state), 4);
    chk("oc_code",  64'(o_fault_code), 1);
    chk("oc_cnt",   64'(o_fault_cnt), 1);
    chk("oc_gate",  64'(o_enable), 0);
    run(3);
    chk("fault_hold", 64'(o_state), 4);
    en = 1'b0;
    run(1);
    chk("fault_exit", 64'(o_state), 0);
    chk("fault_exit_code", 64'(o_fault_code), 0);

    // Out-of-range filter: 2 high, 1 low, then 3 high.
    target = 32'sd350; en = 1'b1;
    wait_state(3, 40);
    or_a = 1'b1; run(2);
    chk("or_two_high", 64'(o_state), 3);
    or_a = 1'b0; run(1);
    or_a = 1'b1; run(2);
    chk("or_two_again", 64'(o_state), 3);
    run(1);
    chk("or_fault", 64'(o_state), 4);
    chk("or_code",  64'(o_fault_code), 2);
    chk("or_cnt",   64'(o_fault_cnt), 2);
    or_a = 1'b0; en = 1'b0;
    run(1);

    // Target reversal mid-ramp.
    en = 1'b1; target = 32'sd350;
    run(17);
    chk("mid_ramp_theta", 64'(o_theta), 200);
    target = -32'sd250;
    for (int k = 0; k < 5; k++) begin
      run(4);
      chk("ramp_down", 64'(o_theta), down_seq[k]);
    end
    chk("ramp_down_run", 64'(o_state), 3);

    // Reset mid-ramp, restart, then full-scale negative current.
    en = 1'b0; run(1);
    en = 1'b1; target = 32'sd350;
    run(17);
    chk("pre_rst_theta", 64'(o_theta), 200);
    rst = 1'b1; run(1);
    chk("rst_mid_state", 64'(o_state), 0);
    chk("rst_mid_theta", 64'(o_theta), 0);
    chk("rst_mid_gate",  64'(o_enable), 0);
    chk("rst_mid_cnt",   64'(o_fault_cnt), 0);
    rst = 1'b0; run(1);
    chk("restart_arm", 64'(o_state), 1);
    wait_state(3, 40);
    ic = -14'sd8192;
    run(1);
    ic = '0;
    chk("neg_fs_state", 64'(o_state), 4);
    chk("neg_fs_code",  64'(o_fault_code), 1);
    chk("neg_fs_cnt",   64'(o_fault_cnt), 1);
    en = 1'b0; run(1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) target = 32'($urandom_range(0, 1200)) - 32'sd600;
      if ($urandom_range(0, 99) < 2) ic = 14'($urandom);
      else ic = 14'($urandom_range(0, 8000)) - 14'sd4000;
      or_a = ($urandom_range(0, 9) < 2);
      or_b = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
